// File: rtl/led7_scan_pkg.sv
// Shared types, segment patterns and helpers for the 7-segment scanner.
// Optional build macro: LED7_SCAN_LZ_BLANK_EN (leading-zero suppression).
package led7_scan_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Active-low gfedcba; non-BCD nibbles show blank
  function automatic logic [6:0] led7_decode(input nibble_t n);
    logic [6:0] s;
    unique case (n)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led7_scan_tick.sv
// Digit-slot prescaler: slot-end tick and anti-ghosting blank window flag.
// Counter is held at zero while disabled so each enable starts a fresh slot.
module led7_scan_tick
  import led7_scan_pkg::*;
#(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic blank
);

  localparam int CW = clog2(PRESCALE);

  logic [CW-1:0] cnt;

  assign tick  = en && (cnt == CW'(PRESCALE - 1));
  assign blank = int'(cnt) < BLANK_CYCLES;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!en || tick)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/led7_scan.sv
// Multiplexed common-anode 7-segment driver with double-buffered value.
// Optional build macro: LED7_SCAN_LZ_BLANK_EN (leading-zero suppression).
module led7_scan
  import led7_scan_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  i_w_clk,
  input  logic                  i_w_reset,
  input  logic                  i_w_en,
  input  logic [4*DIGITS-1:0]   i_w_values,
  input  logic                  i_w_load,
  output logic [6:0]            o_w_seg,
  output logic [DIGITS-1:0]     o_w_an,
  output logic                  o_w_frame_done,
  output logic                  o_w_pending
);

  localparam int IW = clog2(DIGITS);

  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] active_q;
  logic [4*DIGITS-1:0] shadow_q;
  logic                pending;
  logic                tick;
  logic                blank;
  logic                wrap;
  logic                on;
  logic [DIGITS-1:0]   sup;
  nibble_t             cur;
  logic [6:0]          seg_next;

  led7_scan_tick #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_tick (
    .clk   (i_w_clk),
    .rst   (i_w_reset),
    .en    (i_w_en),
    .tick  (tick),
    .blank (blank)
  );

  assign wrap           = tick && (idx == IW'(DIGITS - 1));
  assign on             = i_w_en && !blank;
  assign cur            = active_q[4*idx +: 4];
  assign o_w_frame_done = wrap;
  assign o_w_pending    = pending;

`ifdef LED7_SCAN_LZ_BLANK_EN
  logic lead;
  always_comb begin
    sup  = '0;
    lead = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      sup[k] = lead && (active_q[4*k +: 4] == 4'h0);
      lead   = lead && ((active_q[4*k +: 4] == 4'h0) ||
                        (active_q[4*k +: 4] > 4'h9));
    end
  end
`else
  assign sup = '0;
`endif

  assign seg_next = sup[idx] ? SEG_BLANK : led7_decode(cur);

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset)
      idx <= '0;
    else if (!i_w_en || wrap)
      idx <= '0;
    else if (tick)
      idx <= idx + IW'(1);
  end

  // A load on the wrap edge bypasses the shadow so it lands in this frame
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      active_q <= '1;
      shadow_q <= '1;
      pending  <= 1'b0;
    end else if (i_w_load && wrap) begin
      active_q <= i_w_values;
      shadow_q <= i_w_values;
      pending  <= 1'b0;
    end else if (i_w_load) begin
      shadow_q <= i_w_values;
      pending  <= 1'b1;
    end else if (pending && (wrap || !i_w_en)) begin
      active_q <= shadow_q;
      pending  <= 1'b0;
    end
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      o_w_seg <= SEG_BLANK;
      o_w_an  <= '1;
    end else if (on) begin
      o_w_seg <= seg_next;
      o_w_an  <= ~(DIGITS'(1) << idx);
    end else begin
      o_w_seg <= SEG_BLANK;
      o_w_an  <= '1;
    end
  end

endmodule

// File: tb/tb_led7_scan.sv
// Scoreboard bench for led7_scan (DIGITS=4, PRESCALE=4, BLANK_CYCLES=1).
// Lit anode/segment pairs are queued by stimulus and popped by the monitor.
module tb_led7_scan;

  localparam int DIGITS = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] values = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  led7_scan #(
    .DIGITS       (DIGITS),
    .PRESCALE     (4),
    .BLANK_CYCLES (1)
  ) dut (
    .i_w_clk        (clk),
    .i_w_reset      (rst),
    .i_w_en         (en),
    .i_w_values     (values),
    .i_w_load       (load),
    .o_w_seg        (seg),
    .o_w_an         (an),
    .o_w_frame_done (frame_done),
    .o_w_pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_slot(input logic [3:0] a, input logic [6:0] s,
                           input int n);
    exp_t e;
    e.an  = a;
    e.seg = s;
    repeat (n) q.push_back(e);
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    push_slot(4'hE, s0, 3);
    push_slot(4'hD, s1, 3);
    push_slot(4'hB, s2, 3);
    push_slot(4'h7, s3, 3);
  endtask

  // Monitor: every lit cycle must match the next queued expectation
  always @(negedge clk) begin
    if (!rst && an !== 4'hF) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_lit: got an=%h seg=%h expected none",
                 an, seg);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("scan_an", int'(an), int'(e.an));
        chk("scan_seg", int'(seg), int'(e.seg));
      end
    end
  end

  initial begin
    run(2);
    chk("rst_an", int'(an), 'hF);
    chk("rst_seg", int'(seg), 'h7F);
    chk("rst_pending", int'(pending), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    rst = 1'b0;
    run(1);

    en = 1'b1;
    load = 1'b1;
    values = 16'h1234;
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    push_frame(7'h19, 7'h30, 7'h24, 7'h79);
    run(1);
    load = 1'b0;
    chk("first_pending", int'(pending), 1);
    chk("first_blank_an", int'(an), 'hF);
    run(14);
    chk("fd_pulse1", int'(frame_done), 1);
    chk("pending_before_wrap", int'(pending), 1);
    run(1);
    chk("fd_low_after", int'(frame_done), 0);
    chk("pending_cleared", int'(pending), 0);
    chk("last_slot_an", int'(an), 'h7);
    run(1);
    chk("slot0_blank_an", int'(an), 'hF);

    run(4);
    load = 1'b1;
    values = 16'h5678;
    push_frame(7'h00, 7'h78, 7'h02, 7'h12);
    run(1);
    load = 1'b0;
    chk("midframe_pending", int'(pending), 1);
    run(9);
    chk("fd_pulse2", int'(frame_done), 1);
    chk("midframe_pending_hold", int'(pending), 1);
    run(1);
    chk("midframe_pending_clr", int'(pending), 0);

    run(15);
    chk("fd_pulse3", int'(frame_done), 1);
    load = 1'b1;
    values = 16'h3A90;
    push_slot(4'hE, 7'h40, 3);
    push_slot(4'hD, 7'h18, 3);
    push_slot(4'hB, 7'h7F, 1);
    run(1);
    load = 1'b0;
    chk("wrap_load_pending", int'(pending), 0);
    run(1);
    chk("wrap_load_pending2", int'(pending), 0);
    run(1);
    chk("wrap_load_an", int'(an), 'hE);
    chk("wrap_load_seg", int'(seg), 'h40);

    run(8);
    en = 1'b0;
    run(1);
    chk("dis_an", int'(an), 'hF);
    chk("dis_seg", int'(seg), 'h7F);
    chk("dis_fd", int'(frame_done), 0);
    load = 1'b1;
    values = 16'h0042;
    run(1);
    load = 1'b0;
    chk("dis_load_pending", int'(pending), 1);
    run(1);
    chk("dis_xfer_pending", int'(pending), 0);
    en = 1'b1;
`ifdef LED7_SCAN_LZ_BLANK_EN
    push_frame(7'h24, 7'h19, 7'h7F, 7'h7F);
`else
    push_frame(7'h24, 7'h19, 7'h40, 7'h40);
`endif
    run(1);
    chk("reen_blank_an", int'(an), 'hF);
    run(16);
    chk("frame6_blank_an", int'(an), 'hF);
    load = 1'b1;
    values = 16'h7777;
    push_slot(4'hE, 7'h24, 1);
    run(1);
    load = 1'b0;
    chk("pre_rst_pending", int'(pending), 1);
    run(1);
    rst = 1'b1;
    #1;
    chk("async_rst_an", int'(an), 'hF);
    chk("async_rst_seg", int'(seg), 'h7F);
    chk("async_rst_pending", int'(pending), 0);
    run(2);
    rst = 1'b0;
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    run(1);
    chk("post_rst_pending", int'(pending), 0);
    run(15);
    en = 1'b0;
    run(2);
    chk("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
